demux_route: RTL

//  Registered 1-to-N demultiplexer, the counterpart of the N-to-1 Mux: steers one

---
 rtl/mux_pkg.sv | 31 +++
 rtl/demux_slot.sv | 36 +++
 rtl/demux_route.sv | 75 +++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared select-decode helpers for the lane mux / demux family.
package mux_pkg;

  localparam int DROP_CNT_W = 16;
  localparam int SEL_MAX_W  = 16;

  typedef struct packed {
    logic [SEL_MAX_W-1:0] idx;
    logic                 invalid;
  } sel_dec_t;

  // Priority one-hot (highest set bit wins, all-zero -> 0) or plain encoded index;
  // any index at or beyond n_out is flagged invalid.
  function automatic sel_dec_t sel_decode(input logic [SEL_MAX_W-1:0] sel,
                                          input logic                 one_hot,
                                          input int                   n_out);
    sel_dec_t d;
    d.idx     = '0;
    d.invalid = 1'b0;
    if (one_hot) begin
      for (int i = 0; i < SEL_MAX_W; i++) begin
        if (sel[i]) d.idx = SEL_MAX_W'(i);
      end
    end else begin
      d.idx = sel;
    end
    if (int'(d.idx) >= n_out) d.invalid = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot with valid/ready: load has priority over drain so a lane
// can take a new word in the same cycle its current word leaves.
module demux_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             vld_p1;
  logic [WIDTH-1:0] data_p1;

  // Slot occupancy and contents; data only changes on a load so it holds while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else begin
      if (load) begin
        vld_p1  <= 1'b1;
        data_p1 <= load_data;
      end else if (vld_p1 && out_ready) begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;

endmodule

// File: rtl/demux_route.sv
// Registered 1-to-N demultiplexer: steers each accepted input word into the
// holding slot of the selected lane; words aimed at a nonexistent lane are
// consumed and counted as drops.
module demux_route
  import mux_pkg::*;
#(
  parameter int NOUTPUTS  = 4,
  parameter int WIDTH     = 32,
  parameter int SEL_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_WIDTH-1:0]      in_sel,
  input  logic [WIDTH-1:0]          in_data,
  output logic [NOUTPUTS-1:0]       out_valid,
  input  logic [NOUTPUTS-1:0]       out_ready,
  output logic [NOUTPUTS*WIDTH-1:0] out_data,
  output logic                      drop_pulse,
  output logic [DROP_CNT_W-1:0]     drop_count
);

  localparam logic ONE_HOT = (SEL_WIDTH == NOUTPUTS);
  localparam logic [DROP_CNT_W-1:0] CNT_MAX = '1;

  sel_dec_t              dec_p0;
  logic [NOUTPUTS-1:0]   hit_p0;
  logic [NOUTPUTS-1:0]   load_p0;
  logic                  drop_p0;
  logic                  drop_p1;
  logic [DROP_CNT_W-1:0] drop_cnt_p1;

  // Decode the select into a one-hot lane hit vector (empty when invalid).
  always_comb begin
    dec_p0 = sel_decode(SEL_MAX_W'(in_sel), ONE_HOT, NOUTPUTS);
    hit_p0 = '0;
    for (int k = 0; k < NOUTPUTS; k++) begin
      hit_p0[k] = !dec_p0.invalid && (dec_p0.idx == SEL_MAX_W'(k));
    end
  end

  // Ready depends only on the targeted lane, so a stalled lane blocks only its own traffic.
  assign in_ready = dec_p0.invalid | (|(hit_p0 & (~out_valid | out_ready)));
  assign load_p0  = hit_p0 & {NOUTPUTS{in_valid & in_ready}};
  assign drop_p0  = in_valid & dec_p0.invalid;

  // ---- stage p0 -> p1: per-lane holding slots ----
  for (genvar g = 0; g < NOUTPUTS; g++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_p0[g]),
      .load_data (in_data),
      .out_ready (out_ready[g]),
      .out_valid (out_valid[g]),
      .out_data  (out_data[g*WIDTH +: WIDTH])
    );
  end

  // Drop pulse and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_p1     <= 1'b0;
      drop_cnt_p1 <= '0;
    end else begin
      drop_p1 <= drop_p0;
      if (drop_p0 && drop_cnt_p1 != CNT_MAX) drop_cnt_p1 <= drop_cnt_p1 + 1'b1;
    end
  end

  assign drop_pulse = drop_p1;
  assign drop_count = drop_cnt_p1;

endmodule
